// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bundles of mem_arbiter.
// The master modport always belongs to the side that issues requests on that bundle.
interface mem_arbiter_req_if #(
    parameter int NB_REQ         = 2,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_DATA_WIDTH = 128
);
    logic [NB_REQ-1:0]                req_valid;
    logic [NB_REQ-1:0]                req_ready;
    logic [NB_REQ-1:0]                req_rd;
    logic [NB_REQ-1:0]                req_wr;
    logic [NB_REQ*RAM_ADDR_WIDTH-1:0] req_addr;
    logic [NB_REQ*RAM_DATA_WIDTH-1:0] req_wr_data;
    logic [NB_REQ-1:0]                rsp_valid;
    logic [NB_REQ-1:0]                rsp_ready;
    logic [RAM_DATA_WIDTH-1:0]        rsp_data;

    modport master (
        output req_valid, req_rd, req_wr, req_addr, req_wr_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_rd, req_wr, req_addr, req_wr_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

interface mem_arbiter_mem_if #(
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_DATA_WIDTH = 128
);
    logic                      mem_valid;
    logic                      mem_ready;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [RAM_ADDR_WIDTH-1:0] mem_addr;
    logic [RAM_DATA_WIDTH-1:0] mem_wr_data;
    logic                      mem_rd_valid;
    logic                      mem_rd_ready;
    logic [RAM_DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        output mem_valid, mem_rd, mem_wr, mem_addr, mem_wr_data, mem_rd_ready,
        input  mem_ready, mem_rd_valid, mem_rd_data
    );

    modport slave (
        input  mem_valid, mem_rd, mem_wr, mem_addr, mem_wr_data, mem_rd_ready,
        output mem_ready, mem_rd_valid, mem_rd_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory_driver port between NB_REQ requesters;
// an order FIFO of grant IDs routes in-order read completions back to their owner.
module mem_arbiter #(
    parameter int NB_REQ         = 2,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int RAM_DATA_WIDTH = 128,
    parameter int RD_FIFO_DEPTH  = 4
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    mem_arbiter_req_if.slave                 req,
    mem_arbiter_mem_if.master                mem,
    output logic [$clog2(RD_FIFO_DEPTH):0]   rd_pending,
    output logic                             err_unexp_rd
);

    localparam int GW = $clog2(NB_REQ);
    localparam int PW = $clog2(RD_FIFO_DEPTH);

    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    localparam logic [GW-1:0] LAST_RST  = GW'(NB_REQ - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(RD_FIFO_DEPTH);

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]   rd_pending_q, rd_pending_d;
    logic          err_q, err_d;

    logic [GW-1:0] fifo_mem_q [RD_FIFO_DEPTH];

    logic          fifo_full;
    logic          fifo_empty;
    logic [GW-1:0] head;
    logic          push;
    logic          pop;

    logic          arb_found;
    logic [GW-1:0] arb_pick;
    logic [GW-1:0] arb_cand;

    logic          issue_valid;
    logic          handshake;
    logic          rd_ready_c;

    // Occupancy is taken from the registered pointers only, so a pop cannot
    // open a slot for a push in the same cycle.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == FIFO_FULL);
    assign head       = fifo_mem_q[rd_ptr_q[PW-1:0]];

    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = last_q;
        arb_cand  = last_q;
        for (int i = 1; i <= NB_REQ; i++) begin
            arb_cand = GW'((int'(last_q) + i) % NB_REQ);
            if (!arb_found && req.req_valid[arb_cand]) begin
                arb_pick  = arb_cand;
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        push            = 1'b0;
        issue_valid     = 1'b0;
        handshake       = 1'b0;
        req.req_ready   = '0;
        mem.mem_rd      = 1'b0;
        mem.mem_wr      = 1'b0;
        mem.mem_addr    = '0;
        mem.mem_wr_data = '0;

        case (state_q)
            ARB: begin
                if (arb_found) begin
                    grant_d = arb_pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem.mem_rd      = req.req_rd[grant_q];
                mem.mem_wr      = req.req_wr[grant_q];
                mem.mem_addr    = req.req_addr[grant_q*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
                mem.mem_wr_data = req.req_wr_data[grant_q*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
                issue_valid     = req.req_valid[grant_q] & (!req.req_rd[grant_q] | !fifo_full);
                handshake       = issue_valid & mem.mem_ready;
                if (handshake) begin
                    req.req_ready[grant_q] = 1'b1;
                    push    = req.req_rd[grant_q];
                    last_d  = grant_q;
                    state_d = ARB;
                end else if (!req.req_valid[grant_q]) begin
                    // Requester withdrew before acceptance: drop the grant.
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign mem.mem_valid = issue_valid;

    always_comb begin
        req.rsp_valid       = '0;
        req.rsp_valid[head] = mem.mem_rd_valid & !fifo_empty;
        rd_ready_c          = !fifo_empty & req.rsp_ready[head];
    end

    assign mem.mem_rd_ready = rd_ready_c;
    assign req.rsp_data     = mem.mem_rd_data;
    assign pop              = mem.mem_rd_valid & rd_ready_c;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + {{PW{1'b0}}, push};
        rd_ptr_d     = rd_ptr_q + {{PW{1'b0}}, pop};
        rd_pending_d = wr_ptr_d - rd_ptr_d;
        err_d        = err_q | (mem.mem_rd_valid & fifo_empty);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ARB;
            grant_q      <= '0;
            last_q       <= LAST_RST;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_pending_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_pending_q <= rd_pending_d;
            err_q        <= err_d;
        end
    end

    // NOTE: the FIFO storage has no reset; entries are only read while the
    // reset-cleared pointers say they are valid.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[PW-1:0]] <= grant_q;
        end
    end

    assign rd_pending   = rd_pending_q;
    assign err_unexp_rd = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven arbitration vectors plus
// hand-written read-routing, backpressure, error and reset sequences.
module tb_mem_arbiter;

    localparam int NB     = 3;
    localparam int AW     = 16;
    localparam int DW     = 128;
    localparam int DEPTH  = 4;
    localparam int PEND_W = $clog2(DEPTH) + 1;
    localparam int NVEC   = 13;

    logic aclk = 1'b0;
    logic aresetn;
    logic [PEND_W-1:0] rd_pending;
    logic err_unexp_rd;

    always #5 aclk = ~aclk;

    mem_arbiter_req_if #(.NB_REQ(NB), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) req_if ();
    mem_arbiter_mem_if #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) mem_if ();

    mem_arbiter #(
        .NB_REQ(NB), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RD_FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .req          (req_if),
        .mem          (mem_if),
        .rd_pending   (rd_pending),
        .err_unexp_rd (err_unexp_rd)
    );

    typedef struct {
        int          port;
        logic        rd;
        logic        wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_exp_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } rsp_exp_t;

    typedef struct {
        logic [NB-1:0] mask;
        int            exp_port;
    } arb_vec_t;

    mem_exp_t mem_q [$];
    rsp_exp_t rsp_q [$];
    mem_exp_t me;
    rsp_exp_t re;
    arb_vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always @(posedge aclk) cycle++;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] vaddr(input int p, input int i);
        return AW'(p * 16'h1000 + i);
    endfunction

    function automatic logic [DW-1:0] vdata(input int p, input int i);
        return {32'hC0DE_0000 | 32'(p), 32'(i), 64'h0123_4567_89AB_CDEF};
    endfunction

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge aclk) begin
        if (aresetn && mem_if.mem_valid && mem_if.mem_ready) begin
            if (mem_q.size() == 0) begin
                check("unexpected mem request", 1, 0);
            end else begin
                me = mem_q.pop_front();
                check("mem req_ready", DW'(req_if.req_ready), DW'(1 << me.port));
                check("mem_rd", DW'(mem_if.mem_rd), DW'(me.rd));
                check("mem_wr", DW'(mem_if.mem_wr), DW'(me.wr));
                check("mem_addr", DW'(mem_if.mem_addr), DW'(me.addr));
                check("mem_wr_data", mem_if.mem_wr_data, me.data);
            end
        end
        if (aresetn && mem_if.mem_rd_valid && mem_if.mem_rd_ready) begin
            if (rsp_q.size() == 0) begin
                check("unexpected read response", 1, 0);
            end else begin
                re = rsp_q.pop_front();
                check("rsp_valid route", DW'(req_if.rsp_valid), DW'(1 << re.port));
                check("rsp_data", req_if.rsp_data, re.data);
            end
        end
    end

    task automatic clear_reqs();
        req_if.req_valid   = '0;
        req_if.req_rd      = '0;
        req_if.req_wr      = '0;
        req_if.req_addr    = '0;
        req_if.req_wr_data = '0;
    endtask

    task automatic drive_port(input int p, input logic rd, input logic wr,
                              input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_if.req_valid[p]             = 1'b1;
        req_if.req_rd[p]                = rd;
        req_if.req_wr[p]                = wr;
        req_if.req_addr[p*AW +: AW]     = addr;
        req_if.req_wr_data[p*DW +: DW]  = data;
    endtask

    task automatic expect_req(input int p, input logic rd, input logic wr,
                              input logic [AW-1:0] addr, input logic [DW-1:0] data);
        mem_exp_t e;
        e.port = p; e.rd = rd; e.wr = wr; e.addr = addr; e.data = data;
        mem_q.push_back(e);
    endtask

    task automatic wait_accept(input int exp_port, input string name, output int acc_cycle);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge aclk);
            if (|req_if.req_ready) seen = 1'b1;
        end
        if (!seen) check({name, " accept timeout"}, 0, 1);
        else       check({name, " grant"}, DW'(req_if.req_ready), DW'(1 << exp_port));
        @(posedge aclk); #1;
        acc_cycle = cycle;
    endtask

    task automatic issue_read(input int p, input logic [AW-1:0] addr, input string name);
        int acc;
        clear_reqs();
        drive_port(p, 1'b1, 1'b0, addr, '0);
        expect_req(p, 1'b1, 1'b0, addr, '0);
        wait_accept(p, name, acc);
        clear_reqs();
    endtask

    task automatic complete(input int p, input logic [DW-1:0] data, input string name);
        rsp_exp_t e;
        bit seen = 1'b0;
        @(posedge aclk); #1;
        e.port = p; e.data = data;
        rsp_q.push_back(e);
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = data;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge aclk);
            if (mem_if.mem_rd_ready) seen = 1'b1;
        end
        if (!seen) check({name, " completion timeout"}, 0, 1);
        @(posedge aclk); #1;
        mem_if.mem_rd_valid = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, " mem_valid"}, DW'(mem_if.mem_valid), 0);
        check({name, " req_ready"}, DW'(req_if.req_ready), 0);
        check({name, " rsp_valid"}, DW'(req_if.rsp_valid), 0);
        check({name, " mem_rd_ready"}, DW'(mem_if.mem_rd_ready), 0);
        check({name, " rd_pending"}, DW'(rd_pending), 0);
        check({name, " err_unexp_rd"}, DW'(err_unexp_rd), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev_acc;
        logic [DW-1:0] d;

        // Arbitration vectors for NB=3, starting from last=2 after reset.
        vecs[0]  = '{3'b011, 0};
        vecs[1]  = '{3'b011, 1};
        vecs[2]  = '{3'b011, 0};
        vecs[3]  = '{3'b011, 1};
        vecs[4]  = '{3'b111, 2};
        vecs[5]  = '{3'b111, 0};
        vecs[6]  = '{3'b100, 2};
        vecs[7]  = '{3'b110, 1};
        vecs[8]  = '{3'b101, 2};
        vecs[9]  = '{3'b001, 0};
        vecs[10] = '{3'b110, 1};
        vecs[11] = '{3'b111, 2};
        vecs[12] = '{3'b011, 0};

        aresetn = 1'b0;
        clear_reqs();
        req_if.rsp_ready    = '1;
        mem_if.mem_ready    = 1'b1;
        mem_if.mem_rd_valid = 1'b0;
        mem_if.mem_rd_data  = '0;
        prev_acc = 0;

        repeat (3) @(negedge aclk);
        check_idle("reset");
        @(posedge aclk); #1;
        aresetn = 1'b1;

        // Round-robin table: all writes, driven back-to-back.
        for (int i = 0; i < NVEC; i++) begin
            for (int p = 0; p < NB; p++) begin
                if (vecs[i].mask[p]) drive_port(p, 1'b0, 1'b1, vaddr(p, i), vdata(p, i));
            end
            expect_req(vecs[i].exp_port, 1'b0, 1'b1, vaddr(vecs[i].exp_port, i),
                       vdata(vecs[i].exp_port, i));
            wait_accept(vecs[i].exp_port, $sformatf("arb vec %0d", i), acc);
            if (i > 0) check($sformatf("accept interval vec %0d", i), DW'(acc - prev_acc), 2);
            prev_acc = acc;
            clear_reqs();
        end

        // Read routing: port1 then port0, completions D1 then D2.
        issue_read(1, 16'h0010, "route rd p1");
        issue_read(0, 16'h0020, "route rd p0");
        check("route rd_pending", DW'(rd_pending), 2);
        complete(1, 128'hD1D1_D1D1_0000_0000_0000_0000_0000_00D1, "route D1");
        complete(0, 128'hD2D2_D2D2_0000_0000_0000_0000_0000_00D2, "route D2");
        check("route drained", DW'(rd_pending), 0);

        // Backpressure: fill the order FIFO, 5th read must stall.
        for (int k = 0; k < DEPTH; k++) issue_read(2, AW'(16'h0040 + k), $sformatf("fill %0d", k));
        check("full rd_pending", DW'(rd_pending), DEPTH);
        drive_port(0, 1'b1, 1'b0, 16'h0050, '0);
        expect_req(0, 1'b1, 1'b0, 16'h0050, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            check($sformatf("full stall cycle %0d", k), DW'(mem_if.mem_valid), 0);
        end
        check("full stall rd_pending", DW'(rd_pending), DEPTH);
        @(posedge aclk); #1;
        d = 128'hB0B0_0000_0000_0000_0000_0000_0000_0040;
        re.port = 2; re.data = d;
        rsp_q.push_back(re);
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = d;
        @(negedge aclk);
        check("no same-cycle pop-then-push", DW'(mem_if.mem_valid), 0);
        check("pop accepted", DW'(mem_if.mem_rd_ready), 1);
        @(posedge aclk); #1;
        mem_if.mem_rd_valid = 1'b0;
        @(negedge aclk);
        check("issue after pop", DW'(mem_if.mem_valid), 1);
        check("issue after pop ready", DW'(req_if.req_ready), DW'(3'b001));
        @(posedge aclk); #1;
        clear_reqs();
        @(negedge aclk);
        check("refilled rd_pending", DW'(rd_pending), DEPTH);

        // Requester backpressure on the response path.
        @(posedge aclk); #1;
        d = 128'h5151_0000_0000_0000_0000_0000_0000_0041;
        re.port = 2; re.data = d;
        rsp_q.push_back(re);
        req_if.rsp_ready    = 3'b011;
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = d;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check($sformatf("rsp stall rd_ready %0d", k), DW'(mem_if.mem_rd_ready), 0);
            check($sformatf("rsp stall valid %0d", k), DW'(req_if.rsp_valid), DW'(3'b100));
            check($sformatf("rsp stall data %0d", k), req_if.rsp_data, d);
            @(posedge aclk); #1;
        end
        req_if.rsp_ready = '1;
        @(negedge aclk);
        check("rsp accepted on ready", DW'(mem_if.mem_rd_ready), 1);
        @(posedge aclk); #1;
        mem_if.mem_rd_valid = 1'b0;
        complete(2, 128'h0000_0000_0000_0000_0000_0000_0000_0042, "drain 42");
        complete(2, 128'h0000_0000_0000_0000_0000_0000_0000_0043, "drain 43");
        complete(0, 128'h0000_0000_0000_0000_0000_0000_0000_0050, "drain 50");
        check("drained rd_pending", DW'(rd_pending), 0);

        // Completion with nothing outstanding.
        mem_if.mem_rd_valid = 1'b1;
        mem_if.mem_rd_data  = 128'hBAD;
        @(negedge aclk);
        check("unexp mem_rd_ready", DW'(mem_if.mem_rd_ready), 0);
        check("unexp rsp_valid", DW'(req_if.rsp_valid), 0);
        @(posedge aclk); #1;
        mem_if.mem_rd_valid = 1'b0;
        @(negedge aclk);
        check("err_unexp_rd set", DW'(err_unexp_rd), 1);
        repeat (3) @(negedge aclk);
        check("err_unexp_rd sticky", DW'(err_unexp_rd), 1);

        // rd=wr=1 is forwarded unchanged and still routed as a read.
        @(posedge aclk); #1;
        drive_port(1, 1'b1, 1'b1, 16'h0077, 128'h77);
        expect_req(1, 1'b1, 1'b1, 16'h0077, 128'h77);
        wait_accept(1, "rdwr", acc);
        clear_reqs();
        check("rdwr pushed", DW'(rd_pending), 1);
        complete(1, 128'h7777, "rdwr completion");

        // Reset mid-ISSUE with a read outstanding and last=0.
        issue_read(0, 16'h0088, "pre-reset read");
        mem_if.mem_ready = 1'b0;
        drive_port(1, 1'b0, 1'b1, 16'h0099, 128'h99);
        @(negedge aclk);
        @(negedge aclk);
        check("stalled issue mem_valid", DW'(mem_if.mem_valid), 1);
        #2 aresetn = 1'b0;
        @(negedge aclk);
        check_idle("mid-op reset");
        clear_reqs();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        mem_if.mem_ready = 1'b1;
        drive_port(0, 1'b0, 1'b1, 16'h00A0, 128'hA0);
        drive_port(1, 1'b0, 1'b1, 16'h00A1, 128'hA1);
        expect_req(0, 1'b0, 1'b1, 16'h00A0, 128'hA0);
        wait_accept(0, "first grant after reset", acc);
        clear_reqs();
        @(negedge aclk);
        check("post-reset rd_pending", DW'(rd_pending), 0);

        repeat (2) @(negedge aclk);
        check("mem scoreboard drained", DW'(mem_q.size()), 0);
        check("rsp scoreboard drained", DW'(rsp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
